// File: rtl/qpsk_pkg.sv
// Shared definitions for the QPSK receive path: mode encodings and default sizes.
package qpsk_pkg;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_STROBE = 2'd1,
    MODE_KEEP_N = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_FIFO_AW = 5;
  localparam int DEF_LEN_W   = 12;

  // The reserved encoding behaves exactly like strobe-select.
  function automatic mode_e norm_mode(input logic [1:0] m);
    return (m == MODE_RSVD) ? MODE_STROBE : mode_e'(m);
  endfunction

endpackage

// File: rtl/sym_fifo.sv
// Synchronous FIFO with occupancy output; a pop frees a slot for a same-cycle push when full.
module sym_fifo #(
  parameter int DW = 33,
  parameter int AW = 5
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clear,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_data,
  output logic          o_empty,
  output logic          o_full,
  output logic [AW:0]   o_level
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] r_mem [2**AW];
  logic [AW:0]   r_wr;
  logic [AW:0]   r_rd;
  logic          w_push;
  logic          w_pop;

  assign o_level = r_wr - r_rd;
  assign o_empty = (o_level == '0);
  assign o_full  = (o_level == DEPTH);
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  // Head is zeroed when empty so nothing stale is visible on the output bus.
  assign o_data  = o_empty ? '0 : r_mem[r_rd[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else if (i_clear) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_clear) r_mem[r_wr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/symbol_packetizer.sv
// Selects symbols from an I/Q sample stream (pass, strobe, keep-one-in-n) and frames them
// into fixed-length packets through an output FIFO.
module symbol_packetizer
  import qpsk_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int FIFO_AW = DEF_FIFO_AW,
  parameter int LEN_W   = DEF_LEN_W
) (
  input  logic               ce_clk,
  input  logic               ce_rst_n,
  input  logic               clear,
  input  logic [1:0]         mode,
  input  logic [15:0]        n,
  input  logic [LEN_W-1:0]   pkt_len,
  input  logic               sym_strobe,
  input  logic [WIDTH-1:0]   i_tdata,
  input  logic               i_tvalid,
  output logic               i_tready,
  input  logic               i_tlast,
  output logic [WIDTH-1:0]   o_tdata,
  output logic               o_tvalid,
  input  logic               o_tready,
  output logic               o_tlast,
  output logic [15:0]        drop_cnt,
  output logic [FIFO_AW:0]   fifo_level
);

  logic             r_run;
  logic             r_load;
  logic [1:0]       r_mode;
  logic             r_pend;
  logic [15:0]      r_dcnt;
  logic [15:0]      r_n;
  logic [LEN_W-1:0] r_scnt;
  logic [LEN_W-1:0] r_len;
  logic [15:0]      r_drop;

  mode_e            w_mode;
  logic             w_mode_chg;
  logic [15:0]      w_n_in;
  logic [LEN_W-1:0] w_len_in;
  logic [15:0]      w_n_cur;
  logic [LEN_W-1:0] w_len_cur;
  logic             w_pend_cur;
  logic [15:0]      w_dcnt_cur;
  logic             w_full;
  logic             w_empty;
  logic             w_acc;
  logic             w_pop;
  logic             w_sel;
  logic             w_room;
  logic             w_push;
  logic             w_drop;
  logic             w_cnt_end;
  logic             w_last;
  logic             w_wrap;
  logic [WIDTH:0]   w_head;

  assign w_mode     = norm_mode(mode);
  assign w_mode_chg = (mode != r_mode);
  assign w_n_in     = (n == 16'd0) ? 16'd1 : n;
  assign w_len_in   = (pkt_len == '0) ? LEN_W'(1) : pkt_len;
  // Live n/pkt_len are used only on the cycle they are (re)loaded; otherwise the held copy.
  assign w_n_cur    = (r_load || w_mode_chg) ? w_n_in : r_n;
  assign w_len_cur  = r_load ? w_len_in : r_len;
  assign w_pend_cur = r_pend & ~w_mode_chg;
  assign w_dcnt_cur = w_mode_chg ? 16'd0 : r_dcnt;

  assign i_tready = r_run & ((w_mode != MODE_PASS) | ~w_full);
  assign w_acc    = i_tvalid & i_tready;
  assign w_pop    = ~w_empty & o_tready;

  always_comb begin
    w_sel = 1'b0;
    case (w_mode)
      MODE_PASS:   w_sel = w_acc;
      MODE_STROBE: w_sel = w_acc & (sym_strobe | w_pend_cur);
      MODE_KEEP_N: w_sel = w_acc & (w_dcnt_cur == (w_n_cur - 16'd1));
      default:     w_sel = 1'b0;
    endcase
  end

  assign w_room    = ~w_full | w_pop;
  assign w_push    = w_sel & w_room & ~clear;
  assign w_drop    = w_sel & ~w_room;
  assign w_cnt_end = (r_scnt == (w_len_cur - LEN_W'(1)));
  assign w_last    = (w_mode == MODE_PASS) ? i_tlast : w_cnt_end;
  assign w_wrap    = w_push & (w_last | w_cnt_end);

  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      r_run  <= 1'b0;
      r_load <= 1'b1;
      r_mode <= MODE_PASS;
      r_pend <= 1'b0;
      r_dcnt <= '0;
      r_n    <= 16'd1;
      r_scnt <= '0;
      r_len  <= LEN_W'(1);
      r_drop <= '0;
    end else begin
      r_run  <= 1'b1;
      r_mode <= mode;
      if (clear) begin
        r_load <= 1'b1;
        r_pend <= 1'b0;
        r_dcnt <= '0;
        r_scnt <= '0;
        r_drop <= '0;
      end else begin
        r_load <= 1'b0;
        if (r_load) r_len <= w_len_in;
        if (r_load || w_mode_chg) r_n <= w_n_in;

        // A strobe with no accepted beat arms the flag; repeated strobes just keep it set.
        if (w_mode == MODE_STROBE) begin
          if (w_sel)           r_pend <= 1'b0;
          else if (sym_strobe) r_pend <= 1'b1;
          else                 r_pend <= w_pend_cur;
        end else begin
          r_pend <= 1'b0;
        end

        // A dropped selection holds the count so the next beat is retried.
        if (w_mode == MODE_KEEP_N) begin
          if (w_push) begin
            r_dcnt <= '0;
            r_n    <= w_n_in;
          end else if (w_acc && !w_sel) begin
            r_dcnt <= w_dcnt_cur + 16'd1;
          end else begin
            r_dcnt <= w_dcnt_cur;
          end
        end else begin
          r_dcnt <= '0;
        end

        if (w_push) begin
          if (w_wrap) begin
            r_scnt <= '0;
            r_len  <= w_len_in;
          end else begin
            r_scnt <= r_scnt + LEN_W'(1);
          end
        end

        if (w_drop && (r_drop != 16'hFFFF)) r_drop <= r_drop + 16'd1;
      end
    end
  end

  sym_fifo #(
    .DW (WIDTH + 1),
    .AW (FIFO_AW)
  ) u_fifo (
    .i_clk   (ce_clk),
    .i_rst_n (ce_rst_n),
    .i_clear (clear),
    .i_push  (w_push),
    .i_data  ({w_last, i_tdata}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_level (fifo_level)
  );

  assign o_tvalid = ~w_empty;
  assign o_tdata  = w_head[WIDTH-1:0];
  assign o_tlast  = w_head[WIDTH];
  assign drop_cnt = r_drop;

endmodule

// File: doc/symbol_packetizer.md
SYMBOL_PACKETIZER -- requirements
Module: symbol_packetizer

Interface
REQ-001 SHALL have parameter WIDTH, default 32: sample width (I in upper half, Q in lower half).
REQ-002 SHALL have parameter FIFO_AW, default 5: FIFO depth is 2**FIFO_AW entries.
REQ-003 SHALL have parameter LEN_W, default 12: width of pkt_len.
REQ-004 SHALL have port ce_clk, input, 1: sole clock; single clock domain, all logic on its rising edge.
REQ-005 SHALL have port ce_rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port clear, input, 1: synchronous flush of FIFO, counters and pending state.
REQ-007 SHALL have port mode, input, 2: 0 pass-through, 1 strobe-select, 2 keep-one-in-n, 3 reserved (behaves as 1).
REQ-008 SHALL have port n, input, 16: decimation factor for mode 2; 0 treated as 1.
REQ-009 SHALL have port pkt_len, input, LEN_W: symbols per output packet; 0 treated as 1.
REQ-010 SHALL have port sym_strobe, input, 1: symbol-timing pulse from the bit-sync block.
REQ-011 SHALL have ports i_tdata (input, WIDTH), i_tvalid (input, 1), i_tready (output, 1), i_tlast (input, 1): AXI-stream sample input.
REQ-012 SHALL have ports o_tdata (output, WIDTH), o_tvalid (output, 1), o_tready (input, 1), o_tlast (output, 1): AXI-stream symbol output.
REQ-013 SHALL have port drop_cnt, output, 16: count of symbols dropped on a full FIFO.
REQ-014 SHALL have port fifo_level, output, FIFO_AW+1: current FIFO occupancy.

Function
REQ-015 SHALL accept an input beat only on i_tvalid && i_tready.
REQ-016 SHALL drive i_tready = FIFO not full in mode 0; i_tready SHALL be 1 in modes 1, 2 and 3.
REQ-017 SHALL, in mode 0, push every accepted beat; no drops.
REQ-018 SHALL, in mode 1, latch sym_strobe into a pending flag when it occurs without an accepted beat, and push the next accepted beat; strobe and beat in the same cycle push that beat; further strobes while pending SHALL NOT stack.
REQ-019 SHALL, in mode 2, count accepted beats 0..n-1 and push the beat at count n-1, then wrap to 0.
REQ-020 SHALL, when a selected beat meets a full FIFO in modes 1/2/3, drop it and increment drop_cnt, saturating at 16'hFFFF.
REQ-021 SHALL keep a symbol counter 0..pkt_len-1 advanced per push; the push at pkt_len-1 SHALL store last=1 and wrap the counter to 0.
REQ-022 SHALL sample pkt_len and n only at counter wrap or after clear/reset; mid-packet changes SHALL take effect at the next boundary.
REQ-023 SHALL NOT advance the symbol counter or decimation counter for dropped symbols; i_tlast SHALL be ignored in modes 1/2/3 and forwarded as stored last in mode 0.
REQ-024 SHALL store {last, data} in the FIFO; o_tvalid = FIFO not empty, o_tdata/o_tlast = head entry.
REQ-025 SHALL have first-word latency of one cycle: a push at edge k makes o_tvalid high after edge k.
REQ-026 SHALL hold o_tdata/o_tlast stable while o_tvalid && !o_tready.
REQ-027 SHALL support simultaneous push and pop when full (pop frees the slot in the same cycle) and when empty (level goes 0->1).
REQ-028 SHALL, on a mode change, reset the pending flag and decimation counter but not the FIFO or symbol counter.
REQ-029 SHALL, on clear, empty the FIFO and zero all counters and drop_cnt in the next cycle, overriding any same-cycle push or pop.

Reset
REQ-030 SHALL, while ce_rst_n = 0, force o_tvalid=0, o_tlast=0, o_tdata=0, i_tready=0, drop_cnt=0, fifo_level=0, pending=0 and all counters to 0.
REQ-031 SHALL, when reset asserts mid-packet, discard the partial packet; after deassertion the first pushed symbol SHALL start a new packet.

Structure
REQ-032 SHALL take mode encodings (MODE_PASS, MODE_STROBE, MODE_KEEP_N) and default parameter constants from the shared package qpsk_pkg.
REQ-033 SHALL contain one sub-module, sym_fifo (synchronous FIFO, width WIDTH+1, depth 2**FIFO_AW, with level output).

Verification
REQ-034 SHALL verify mode 2: n=4, pkt_len=3, continuous input 0..23 -> outputs 3,7,11 | 15,19,23; o_tlast on 11 and 23.
REQ-035 SHALL verify mode 1: strobes on cycles with no valid beat, next beats 0x10, 0x20 -> 0x10 pushed once, no double push.
REQ-036 SHALL verify overflow: FIFO_AW=2, o_tready=0, 6 selected symbols -> fifo_level=4, drop_cnt=2, first 4 preserved in order.
REQ-037 SHALL verify a pkt_len change 4->2 after the 2nd symbol -> current packet ends at 4 symbols, later packets are 2 symbols.
REQ-038 SHALL verify reset/clear mid-packet: both assert at level 3 -> o_tvalid=0 next cycle, drop_cnt=0, next packet full length.
REQ-039 SHALL verify mode 0 backpressure: o_tready toggling 50% -> i_tready low when full, all beats out in order with i_tlast preserved.
